// File: rtl/spi_cmd_pkg.sv
// spi_cmd_ctrl shared definitions: opcodes, FSM states, address-width bounds.
// Streaming build option: SPI_CMD_STREAM_EN.
package spi_cmd_pkg;

  localparam logic [3:0] OP_WRITE_AT   = 4'h8;
  localparam logic [3:0] OP_WRITE_NEXT = 4'h9;
  localparam logic [3:0] OP_READ_AT    = 4'hC;
  localparam logic [3:0] OP_READ_NEXT  = 4'hD;

  localparam int ADDR_W_MIN = 16;
  localparam int ADDR_W_MAX = 20;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_ADDR_HI,
    S_ADDR_LO,
    S_DATA,
    S_REQ,
    S_WAIT_ACK,
    S_STREAM,
    S_DISCARD
  } state_e;

  function automatic logic addr_width_ok(input int w);
    return (w >= ADDR_W_MIN) && (w <= ADDR_W_MAX);
  endfunction

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op == OP_WRITE_AT)  || (op == OP_WRITE_NEXT) ||
           (op == OP_READ_AT)   || (op == OP_READ_NEXT);
  endfunction

endpackage

// File: rtl/spi_cmd_ctrl.sv
// SPI command sequencer: parses framed command bytes into single bus accesses.
// Define SPI_CMD_STREAM_EN to repeat accesses for extra bytes in a frame.
module spi_cmd_ctrl
  import spi_cmd_pkg::*;
#(
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk_sys_i,
  input  logic                  reset_i,
  input  logic                  cs_active_i,
  input  logic                  rx_valid_i,
  input  logic [7:0]            rx_byte_i,
  output logic [7:0]            tx_byte_o,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [7:0]            bus_data_o,
  input  logic                  bus_ack_i,
  input  logic [7:0]            bus_data_i,
  output logic                  busy_o,
  output logic                  overrun_o
);

  if (!addr_width_ok(ADDR_WIDTH)) begin : g_bad_aw
    $error("spi_cmd_ctrl: ADDR_WIDTH out of range");
  end

  localparam logic [ADDR_WIDTH-1:0] ONE =
    {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

`ifdef SPI_CMD_STREAM_EN
  localparam state_e S_AFTER = S_STREAM;
`else
  localparam state_e S_AFTER = S_DISCARD;
`endif

  state_e                state_q, state_d;
  logic [3:0]            op_q, op_d;
  logic [3:0]            bank_q, bank_d;
  logic [7:0]            hi_q, hi_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] last_q, last_d;
  logic [7:0]            data_q, data_d;
  logic                  we_q, we_d;
  logic [7:0]            tx_q, tx_d;
  logic                  ovr_q, ovr_d;
  logic                  cs_q;

  logic                  req_active;
  logic                  ack;
  state_e                after_ack;
  logic [ADDR_W_MAX-1:0] addr_full;

  // READ_NEXT has no operands, so its request is already live in CMD.
  assign req_active = (state_q == S_REQ) ||
                      (state_q == S_WAIT_ACK) ||
                      ((state_q == S_CMD) &&
                       (op_q == OP_READ_NEXT));
  assign ack        = bus_ack_i && req_active;
  assign after_ack  = cs_active_i ? S_AFTER : S_IDLE;
  assign addr_full  = {bank_q, hi_q, rx_byte_i};

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    bank_d  = bank_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    last_d  = last_q;
    data_d  = data_q;
    we_d    = we_q;
    tx_d    = tx_q;
    ovr_d   = ovr_q;

    if (cs_active_i && !cs_q) ovr_d = 1'b0;
    if (rx_valid_i && req_active) ovr_d = 1'b1;

    if (ack) begin
      last_d = addr_q;
      if (!we_q) tx_d = bus_data_i;
    end

    unique case (state_q)
      S_IDLE: begin
        if (cs_active_i && rx_valid_i) begin
          op_d    = rx_byte_i[7:4];
          bank_d  = rx_byte_i[3:0];
          state_d = S_CMD;
          if (op_is_legal(rx_byte_i[7:4])) begin
            we_d = ~rx_byte_i[6];
            if (rx_byte_i[4]) addr_d = last_q + ONE;
          end
        end
      end
      S_CMD: begin
        if (op_q == OP_READ_NEXT) begin
          state_d = ack ? after_ack : S_WAIT_ACK;
        end else if (!cs_active_i) begin
          state_d = S_IDLE;
        end else begin
          unique case (op_q)
            OP_WRITE_AT,
            OP_READ_AT:    state_d = S_ADDR_HI;
            OP_WRITE_NEXT: state_d = S_DATA;
            default:       state_d = S_DISCARD;
          endcase
        end
      end
      S_ADDR_HI: begin
        if (!cs_active_i) begin
          state_d = S_IDLE;
        end else if (rx_valid_i) begin
          hi_d    = rx_byte_i;
          state_d = S_ADDR_LO;
        end
      end
      S_ADDR_LO: begin
        if (!cs_active_i) begin
          state_d = S_IDLE;
        end else if (rx_valid_i) begin
          addr_d  = ADDR_WIDTH'(addr_full);
          state_d = we_q ? S_DATA : S_REQ;
        end
      end
      S_DATA: begin
        if (!cs_active_i) begin
          state_d = S_IDLE;
        end else if (rx_valid_i) begin
          data_d  = rx_byte_i;
          state_d = S_REQ;
        end
      end
      S_REQ,
      S_WAIT_ACK: begin
        state_d = ack ? after_ack : S_WAIT_ACK;
      end
`ifdef SPI_CMD_STREAM_EN
      S_STREAM: begin
        if (!cs_active_i) begin
          state_d = S_IDLE;
        end else if (rx_valid_i) begin
          addr_d  = last_q + ONE;
          if (we_q) data_d = rx_byte_i;
          state_d = S_REQ;
        end
      end
`endif
      S_DISCARD: begin
        if (!cs_active_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      op_q    <= 4'h0;
      bank_q  <= 4'h0;
      hi_q    <= 8'h00;
      addr_q  <= '0;
      last_q  <= '0;
      data_q  <= 8'h00;
      we_q    <= 1'b0;
      tx_q    <= 8'h00;
      ovr_q   <= 1'b0;
      cs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      bank_q  <= bank_d;
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      data_q  <= data_d;
      we_q    <= we_d;
      tx_q    <= tx_d;
      ovr_q   <= ovr_d;
      cs_q    <= cs_active_i;
    end
  end

  assign bus_req_o  = req_active;
  assign busy_o     = req_active;
  assign bus_we_o   = we_q;
  assign bus_addr_o = addr_q;
  assign bus_data_o = data_q;
  assign tx_byte_o  = tx_q;
  assign overrun_o  = ovr_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Bench for spi_cmd_ctrl: command table plus bus responder scoreboard.
// Also builds with SPI_CMD_STREAM_EN defined.
module tb_spi_cmd_ctrl;

  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          reset;
  logic          cs;
  logic          rx_valid;
  logic [7:0]    rx_byte;
  logic [7:0]    tx_byte;
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [7:0]    bus_wdata;
  logic          bus_ack = 1'b0;
  logic [7:0]    bus_rdata = 8'h00;
  logic          busy;
  logic          overrun;

  always #5 clk = ~clk;

  spi_cmd_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk_sys_i   (clk),
    .reset_i     (reset),
    .cs_active_i (cs),
    .rx_valid_i  (rx_valid),
    .rx_byte_i   (rx_byte),
    .tx_byte_o   (tx_byte),
    .bus_req_o   (bus_req),
    .bus_we_o    (bus_we),
    .bus_addr_o  (bus_addr),
    .bus_data_o  (bus_wdata),
    .bus_ack_i   (bus_ack),
    .bus_data_i  (bus_rdata),
    .busy_o      (busy),
    .overrun_o   (overrun)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } txn_t;

  typedef struct packed {
    logic [4:0][7:0] b;
    int              n;
    int              req_at;
    int              exp_n;
    txn_t [1:0]      t;
    logic [7:0]      rdata;
  } vec_t;

  int         nvec = 0;
  int         nfail = 0;
  txn_t       sb[$];
  int         ack_delay = 2;
  int         txn_cnt = 0;
  logic [7:0] rd_val = 8'h00;

  function automatic txn_t tx(input logic w,
                              input logic [AW-1:0] a,
                              input logic [7:0] d);
    txn_t r;
    r.we = w;
    r.addr = a;
    r.data = d;
    return r;
  endfunction

  function automatic vec_t mk(input int n,
                              input logic [7:0] b0, b1, b2, b3, b4,
                              input int req_at, input int exp_n,
                              input txn_t t0, input txn_t t1,
                              input logic [7:0] rd);
    vec_t r;
    r.b[0] = b0; r.b[1] = b1; r.b[2] = b2;
    r.b[3] = b3; r.b[4] = b4;
    r.n = n;
    r.req_at = req_at;
    r.exp_n = exp_n;
    r.t[0] = t0;
    r.t[1] = t1;
    r.rdata = rd;
    return r;
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Bus responder: acks after ack_delay cycles and checks each access.
  initial begin : responder
    int   wcnt;
    logic chk_after;
    logic after_rd;
    logic [7:0] after_data;
    txn_t e;
    wcnt = 0;
    chk_after = 1'b0;
    after_rd = 1'b0;
    after_data = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (chk_after) begin
        check("req_fall", {31'b0, bus_req}, 0);
        check("busy_fall", {31'b0, busy}, 0);
        if (after_rd) check("tx_byte", {24'b0, tx_byte}, {24'b0, after_data});
        chk_after = 1'b0;
      end
      bus_ack = 1'b0;
      if (!bus_req || reset) begin
        wcnt = 0;
      end else if (wcnt < ack_delay) begin
        wcnt++;
      end else begin
        bus_ack = 1'b1;
        bus_rdata = rd_val;
        wcnt = 0;
        txn_cnt++;
        chk_after = 1'b1;
        after_rd = !bus_we;
        after_data = rd_val;
        if (sb.size() == 0) begin
          nvec++;
          nfail++;
          $display("FAIL unexpected_txn: got we=%0b addr=%0h, expected none",
                   bus_we, bus_addr);
        end else begin
          e = sb.pop_front();
          check("txn_we", {31'b0, bus_we}, {31'b0, e.we});
          check("txn_addr", {15'b0, bus_addr}, {15'b0, e.addr});
          if (e.we) check("txn_data", {24'b0, bus_wdata}, {24'b0, e.data});
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, output logic req_seen);
    @(posedge clk); #1;
    rx_byte = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    req_seen = bus_req;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("idle_timeout", {31'b0, busy}, 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic begin_frame();
    @(posedge clk); #1;
    cs = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic end_frame();
    cs = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  vec_t          vecs[7];
  vec_t          v;
  logic          rs;
  int            base;
  logic [AW-1:0] model_last;
  txn_t          t0;

  initial begin
    t0 = tx(1'b0, '0, 8'h00);
    vecs[0] = mk(4, 8'h81, 8'h23, 8'h45, 8'hA5, 8'h00, 3, 1,
                 tx(1'b1, 17'h12345, 8'hA5), t0, 8'h00);
    vecs[1] = mk(2, 8'h90, 8'h77, 8'h00, 8'h00, 8'h00, 1, 1,
                 tx(1'b1, 17'h12346, 8'h77), t0, 8'h00);
    vecs[2] = mk(3, 8'hC0, 8'h00, 8'h10, 8'h00, 8'h00, 2, 1,
                 tx(1'b0, 17'h00010, 8'h00), t0, 8'h5A);
    vecs[3] = mk(1, 8'hD0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1,
                 tx(1'b0, 17'h00011, 8'h00), t0, 8'h3C);
    vecs[4] = mk(2, 8'h30, 8'h12, 8'h00, 8'h00, 8'h00, -1, 0,
                 t0, t0, 8'h00);
`ifdef SPI_CMD_STREAM_EN
    vecs[5] = mk(5, 8'h81, 8'hFF, 8'hFF, 8'h01, 8'h02, 3, 2,
                 tx(1'b1, 17'h1FFFF, 8'h01),
                 tx(1'b1, 17'h00000, 8'h02), 8'h00);
    vecs[6] = mk(1, 8'hD0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1,
                 tx(1'b0, 17'h00001, 8'h00), t0, 8'hC3);
`else
    vecs[5] = mk(5, 8'h81, 8'hFF, 8'hFF, 8'h01, 8'h02, 3, 1,
                 tx(1'b1, 17'h1FFFF, 8'h01), t0, 8'h00);
    vecs[6] = mk(1, 8'hD0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1,
                 tx(1'b0, 17'h00000, 8'h00), t0, 8'hC3);
`endif

    reset = 1'b1;
    cs = 1'b0;
    rx_valid = 1'b0;
    rx_byte = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_req", {31'b0, bus_req}, 0);
    check("rst_we", {31'b0, bus_we}, 0);
    check("rst_addr", {15'b0, bus_addr}, 0);
    check("rst_data", {24'b0, bus_wdata}, 0);
    check("rst_tx", {24'b0, tx_byte}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_overrun", {31'b0, overrun}, 0);

    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      rd_val = v.rdata;
      base = txn_cnt;
      for (int j = 0; j < v.exp_n; j++) sb.push_back(v.t[j]);
      begin_frame();
      for (int j = 0; j < v.n; j++) begin
        send_byte(v.b[j], rs);
        if (j == v.req_at) check($sformatf("req_rise_v%0d", i), {31'b0, rs}, 1);
        if (v.req_at < 0) check($sformatf("no_req_v%0d", i), {31'b0, rs}, 0);
        wait_idle();
      end
      end_frame();
      check($sformatf("txn_count_v%0d", i), txn_cnt - base, v.exp_n);
      check($sformatf("sb_empty_v%0d", i), sb.size(), 0);
    end
    model_last = vecs[6].t[0].addr;

    // Frame aborted after addr_hi, then READ_NEXT in a new frame.
    rd_val = 8'h96;
    base = txn_cnt;
    sb.push_back(tx(1'b0, model_last + 1'b1, 8'h00));
    begin_frame();
    send_byte(8'h81, rs);
    wait_idle();
    send_byte(8'h23, rs);
    wait_idle();
    end_frame();
    check("abort_no_req", txn_cnt - base, 0);
    begin_frame();
    send_byte(8'hD0, rs);
    check("abort_rn_req", {31'b0, rs}, 1);
    wait_idle();
    end_frame();
    check("abort_txn_count", txn_cnt - base, 1);
    check("abort_sb_empty", sb.size(), 0);

    // Byte arriving during a slow ack is dropped and flagged.
    ack_delay = 40;
    rd_val = 8'hE1;
    base = txn_cnt;
    sb.push_back(tx(1'b0, 17'h00020, 8'h00));
    begin_frame();
    send_byte(8'hC0, rs);
    send_byte(8'h00, rs);
    send_byte(8'h20, rs);
    check("ovr_req_rise", {31'b0, rs}, 1);
    repeat (5) @(posedge clk);
    #1;
    send_byte(8'h55, rs);
    check("ovr_set", {31'b0, overrun}, 1);
    check("ovr_busy_held", {31'b0, busy}, 1);
    wait_idle();
    check("ovr_txn_count", txn_cnt - base, 1);
    check("ovr_sticky", {31'b0, overrun}, 1);
    end_frame();
    check("ovr_cs_fall", {31'b0, overrun}, 1);
    begin_frame();
    check("ovr_clr", {31'b0, overrun}, 0);
    end_frame();

    // Reset while a request is outstanding, then last address must be 0.
    base = txn_cnt;
    begin_frame();
    send_byte(8'hD0, rs);
    repeat (3) @(posedge clk);
    #1;
    check("mid_req_high", {31'b0, bus_req}, 1);
    reset = 1'b1;
    cs = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_req", {31'b0, bus_req}, 0);
    check("mid_rst_busy", {31'b0, busy}, 0);
    reset = 1'b0;
    ack_delay = 2;
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_no_txn", txn_cnt - base, 0);
    rd_val = 8'h4B;
    sb.push_back(tx(1'b0, 17'h00001, 8'h00));
    begin_frame();
    send_byte(8'hD0, rs);
    wait_idle();
    end_frame();
    check("post_rst_txn", txn_cnt - base, 1);
    check("post_rst_sb", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
